router_rx_port: RTL and testbench

- Destination-side reader for one output port of the 1x3 router.
- Watches the port FIFO's valid flag and drives that FIFO's read enable.
- Reassembles packets in the router format: header byte, then 0-63 payload bytes, then one parity byte.
- Streams header and payload to a downstream client with ready/valid backpressure, then checks parity and address and reports per-packet status.

---
 rtl/router_rx_port.sv | 259 +++++++++++++++++++++++++
 tb/tb_router_rx_port.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_rx_port.sv
`default_nettype none
// ============================================================================
//  Module      : router_rx_port
//  Description : Destination-side reader for one output port of the 1x3
//                router. Pulls header / payload / parity bytes out of the
//                port FIFO, streams header and payload downstream through a
//                two-entry skid buffer with ready/valid backpressure, then
//                reports parity and address status for each packet.
//
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                vld_out          - port FIFO non-empty
//                data_out         - FIFO read data (one cycle after read_enb)
//                soft_reset       - port flush, aborts the current packet
//                read_enb         - FIFO read request
//                out_data/out_valid/out_ready/out_sop/out_eop - stream
//                pkt_done/parity_err/addr_err - per-packet status pulse
//                pkt_abort        - packet aborted pulse
//                pkt_count/err_count - statistics counters
//
//  Options     : ROUTER_RX_STATS_EN - when defined, pkt_count and err_count
//                are saturating counters; otherwise both are tied to zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module router_rx_port #(
    parameter int         DATA_W  = 8,
    parameter logic [1:0] PORT_ID = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic              soft_reset,
    output logic              read_enb,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              addr_err,
    output logic              pkt_abort,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
);

    localparam int c_LEN_W = DATA_W - 2;
    // One bit wider than the length field so len+1 never wraps.
    localparam int c_CNT_W = DATA_W - 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_FETCH_HDR  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_HDR   = 3'd2;
    localparam logic [2:0] c_ST_FETCH_BODY = 3'd3;
    localparam logic [2:0] c_ST_DONE       = 3'd4;

    logic [2:0]         r_state;
    logic               r_in_flight;
    logic [c_LEN_W-1:0] r_len;
    logic [c_CNT_W-1:0] r_remaining;
    logic [c_CNT_W-1:0] r_body_cnt;
    logic [DATA_W-1:0]  r_acc;
    logic [1:0]         r_hdr_addr;
    logic               r_par_bad;
    logic               r_pkt_done;
    logic               r_parity_err;
    logic               r_addr_err;
    logic               r_pkt_abort;

    // Skid buffer entry layout: {eop, sop, data}
    logic [DATA_W+1:0]  r_buf [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;

    logic               w_fetch;
    logic               w_credit;
    logic               w_rd;
    logic               w_pop;
    logic               w_abort;
    logic               w_ret_hdr;
    logic               w_ret_body;
    logic               w_is_payload;
    logic               w_push;
    logic [DATA_W+1:0]  w_push_data;
    logic [DATA_W+1:0]  w_head;

    // Body reads stop once the parity byte has been requested.
    assign w_fetch  = (r_state == c_ST_FETCH_HDR) ||
                      ((r_state == c_ST_FETCH_BODY) && (r_remaining != '0));
    // A read is only issued if the byte it returns is guaranteed a slot.
    assign w_credit = (({1'b0, r_count} + {2'b00, r_in_flight}) < 3'd2);
    assign w_rd     = w_fetch && vld_out && !soft_reset && w_credit;
    assign read_enb = w_rd;

    assign w_abort      = soft_reset && (r_state != c_ST_IDLE);
    assign w_ret_hdr    = r_in_flight && (r_state == c_ST_WAIT_HDR);
    assign w_ret_body   = r_in_flight && (r_state == c_ST_FETCH_BODY);
    assign w_is_payload = w_ret_body && (r_body_cnt < {1'b0, r_len});
    assign w_push       = w_ret_hdr || w_is_payload;

    always_comb begin
        w_push_data = '0;
        if (w_ret_hdr) begin
            w_push_data = {(data_out[DATA_W-1:2] == '0), 1'b1, data_out};
        end else begin
            w_push_data = {((r_body_cnt + c_CNT_ONE) == {1'b0, r_len}), 1'b0, data_out};
        end
    end

    assign w_head    = r_buf[r_rd_ptr];
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = out_valid ? w_head[DATA_W-1:0] : '0;
    assign out_sop   = out_valid && w_head[DATA_W];
    assign out_eop   = out_valid && w_head[DATA_W+1];

    assign pkt_done   = r_pkt_done;
    assign parity_err = r_parity_err;
    assign addr_err   = r_addr_err;
    assign pkt_abort  = r_pkt_abort;

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_in_flight  <= 1'b0;
            r_len        <= '0;
            r_remaining  <= '0;
            r_body_cnt   <= '0;
            r_acc        <= '0;
            r_hdr_addr   <= 2'b00;
            r_par_bad    <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_parity_err <= 1'b0;
            r_addr_err   <= 1'b0;
            r_pkt_abort  <= 1'b0;
        end else begin
            r_pkt_done   <= 1'b0;
            r_parity_err <= 1'b0;
            r_addr_err   <= 1'b0;
            r_pkt_abort  <= 1'b0;
            if (w_abort) begin
                // Any byte returning this cycle belongs to the dead packet.
                r_state     <= c_ST_IDLE;
                r_in_flight <= 1'b0;
                r_pkt_abort <= 1'b1;
            end else begin
                r_in_flight <= w_rd;
                case (r_state)
                    c_ST_IDLE: begin
                        if (vld_out) begin
                            r_state <= c_ST_FETCH_HDR;
                        end
                    end
                    c_ST_FETCH_HDR: begin
                        if (w_rd) begin
                            r_state <= c_ST_WAIT_HDR;
                        end
                    end
                    c_ST_WAIT_HDR: begin
                        if (r_in_flight) begin
                            r_len       <= data_out[DATA_W-1:2];
                            r_remaining <= {1'b0, data_out[DATA_W-1:2]} + c_CNT_ONE;
                            r_acc       <= data_out;
                            r_hdr_addr  <= data_out[1:0];
                            r_body_cnt  <= '0;
                            r_par_bad   <= 1'b0;
                            r_state     <= c_ST_FETCH_BODY;
                        end
                    end
                    c_ST_FETCH_BODY: begin
                        if (w_rd) begin
                            r_remaining <= r_remaining - c_CNT_ONE;
                        end
                        if (w_ret_body) begin
                            r_body_cnt <= r_body_cnt + c_CNT_ONE;
                            if (w_is_payload) begin
                                r_acc <= r_acc ^ data_out;
                            end else begin
                                r_par_bad <= (r_acc != data_out);
                            end
                        end
                        if ((r_remaining == '0) && !r_in_flight) begin
                            r_state      <= c_ST_DONE;
                            r_pkt_done   <= 1'b1;
                            r_parity_err <= r_par_bad;
                            r_addr_err   <= (r_hdr_addr != PORT_ID);
                        end
                    end
                    c_ST_DONE: begin
                        r_state <= c_ST_IDLE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef ROUTER_RX_STATS_EN
    logic [15:0] r_pkt_count;
    logic [15:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count <= 16'h0000;
            r_err_count <= 16'h0000;
        end else if (r_pkt_done) begin
            if (r_pkt_count != 16'hFFFF) begin
                r_pkt_count <= r_pkt_count + 16'h0001;
            end
            if ((r_parity_err || r_addr_err) && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'h0001;
            end
        end
    end

    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;
`else
    assign pkt_count = 16'h0000;
    assign err_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_rx_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_rx_port
//  Description : Directed self-checking bench for router_rx_port. A small
//                FIFO model feeds packets; a negedge monitor records stream
//                beats and status pulses for the per-scenario tasks to check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_rx_port;

`ifdef ROUTER_RX_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld_out;
    logic [7:0]  data_out = 8'h00;
    logic        soft_reset = 1'b0;
    logic        read_enb;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic        pkt_done;
    logic        parity_err;
    logic        addr_err;
    logic        pkt_abort;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    router_rx_port #(.DATA_W(8), .PORT_ID(2'b00)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .soft_reset (soft_reset),
        .read_enb   (read_enb),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .pkt_abort  (pkt_abort),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    // FIFO model: one-cycle read latency, flush empties it.
    logic [7:0] fifo_mem [0:1023];
    int         wr_i = 0;
    int         rd_i = 0;
    logic       fifo_flush = 1'b0;

    assign vld_out = (wr_i != rd_i);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_i <= wr_i;
        end else if (read_enb && (wr_i != rd_i)) begin
            data_out <= fifo_mem[rd_i];
            rd_i     <= rd_i + 1;
        end
    end

    // Monitor: beats as {eop, sop, data}
    logic [9:0] cap [0:1023];
    int   cap_n = 0;
    int   done_n = 0;
    int   abort_n = 0;
    int   rd_n = 0;
    logic last_perr = 1'b0;
    logic last_aerr = 1'b0;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            cap[cap_n] <= {out_eop, out_sop, out_data};
            cap_n      <= cap_n + 1;
        end
        if (pkt_done) begin
            done_n    <= done_n + 1;
            last_perr <= parity_err;
            last_aerr <= addr_err;
        end
        if (pkt_abort) abort_n <= abort_n + 1;
        if (read_enb)  rd_n    <= rd_n + 1;
    end

    // Expected beats of the most recently loaded packet
    logic [9:0] exp_beat [0:127];
    int         exp_n = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input logic [7:0] hdr, input int n, input logic [7:0] first,
                            input logic [7:0] step, input bit bad_par);
        logic [7:0] par;
        logic [7:0] b;
        par = hdr;
        b   = first;
        fifo_mem[wr_i] = hdr;
        exp_beat[0] = {(n == 0), 1'b1, hdr};
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_i + 1 + i] = b;
            exp_beat[i + 1] = {(i == n - 1), 1'b0, b};
            par = par ^ b;
            b   = b + step;
        end
        fifo_mem[wr_i + 1 + n] = bad_par ? 8'h00 : par;
        exp_n = n + 1;
        wr_i  = wr_i + n + 2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({read_enb, out_valid, out_sop, out_eop, out_data, pkt_done, pkt_abort,
             parity_err, addr_err} !== 14'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got re=%b v=%b d=%h done=%b abort=%b want all 0",
                     read_enb, out_valid, out_data, pkt_done, pkt_abort);
        end
        tests_run++;
        if ({pkt_count, err_count} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", pkt_count, err_count);
        end
    endtask

    task automatic test_basic;
        int s, d0, r0, t;
        s = cap_n; d0 = done_n; r0 = rd_n;
        load_pkt(8'h08, 2, 8'hA1, 8'h11, 1'b0);   // 08, A1, B2, parity 1B
        t = 0;
        while (done_n == d0 && t < 400) begin @(negedge clk); t++; end
        tests_run++;
        if (done_n == d0) begin
            tests_failed++;
            $display("FAIL basic_done got no pkt_done want pulse");
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (cap_n - s != exp_n) begin
            tests_failed++;
            $display("FAIL basic_beats got %0d want %0d", cap_n - s, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests_run++;
            if (cap[s + i] !== exp_beat[i]) begin
                tests_failed++;
                $display("FAIL basic_beat%0d got %h want %h", i, cap[s + i], exp_beat[i]);
            end
        end
        tests_run++;
        if ({last_perr, last_aerr} !== 2'b00) begin
            tests_failed++;
            $display("FAIL basic_status got perr=%b aerr=%b want 0 0", last_perr, last_aerr);
        end
        tests_run++;
        if (rd_n - r0 != 4) begin
            tests_failed++;
            $display("FAIL basic_reads got %0d want 4", rd_n - r0);
        end
        tests_run++;
        if (pkt_count !== (c_STATS ? 16'd1 : 16'd0)) begin
            tests_failed++;
            $display("FAIL basic_pkt_count got %0d", pkt_count);
        end
    endtask

    task automatic test_parity_err;
        int d0, t;
        d0 = done_n;
        load_pkt(8'h08, 2, 8'hA1, 8'h11, 1'b1);
        t = 0;
        while (done_n == d0 && t < 400) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_n == d0 || {last_perr, last_aerr} !== 2'b10) begin
            tests_failed++;
            $display("FAIL parity_status got done=%0d perr=%b aerr=%b want 1 1 0",
                     done_n - d0, last_perr, last_aerr);
        end
        tests_run++;
        if (err_count !== (c_STATS ? 16'd1 : 16'd0)) begin
            tests_failed++;
            $display("FAIL parity_err_count got %0d", err_count);
        end
    endtask

    task automatic test_addr_err;
        int s, d0, t;
        s = cap_n; d0 = done_n;
        load_pkt(8'h01, 0, 8'h00, 8'h00, 1'b0);
        t = 0;
        while (done_n == d0 && t < 400) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        tests_run++;
        if (cap_n - s != 1 || cap[s] !== 10'h301) begin
            tests_failed++;
            $display("FAIL addr_beat got n=%0d beat=%h want 1 301", cap_n - s, cap[s]);
        end
        tests_run++;
        if (done_n == d0 || {last_perr, last_aerr} !== 2'b01) begin
            tests_failed++;
            $display("FAIL addr_status got done=%0d perr=%b aerr=%b want 1 0 1",
                     done_n - d0, last_perr, last_aerr);
        end
        tests_run++;
        if ({pkt_count, err_count} !== (c_STATS ? {16'd3, 16'd2} : 32'h0)) begin
            tests_failed++;
            $display("FAIL addr_counts got %0d/%0d", pkt_count, err_count);
        end
    endtask

    task automatic test_backpressure;
        int s, d0, t;
        logic [7:0] held;
        held = 8'h00;
        s = cap_n; d0 = done_n;
        load_pkt(8'h18, 6, 8'h11, 8'h01, 1'b0);
        t = 0;
        while (cap_n - s < 2 && t < 400) begin @(negedge clk); t++; end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) held = out_data;
            if (i >= 2) begin
                tests_run++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL bp_hold%0d got v=%b d=%h want 1 %h", i, out_valid, out_data, held);
                end
            end
        end
        tests_run++;
        if (read_enb !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_read_stall got %b want 0", read_enb);
        end
        tick();
        out_ready = 1'b1;
        t = 0;
        while (done_n == d0 && t < 400) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        tests_run++;
        if (cap_n - s != exp_n) begin
            tests_failed++;
            $display("FAIL bp_beats got %0d want %0d", cap_n - s, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            tests_run++;
            if (cap[s + i] !== exp_beat[i]) begin
                tests_failed++;
                $display("FAIL bp_beat%0d got %h want %h", i, cap[s + i], exp_beat[i]);
            end
        end
        tests_run++;
        if (done_n == d0 || {last_perr, last_aerr} !== 2'b00) begin
            tests_failed++;
            $display("FAIL bp_status got perr=%b aerr=%b want 0 0", last_perr, last_aerr);
        end
    endtask

    task automatic test_soft_reset;
        int s, d0, a0, t;
        s = cap_n; d0 = done_n; a0 = abort_n;
        load_pkt(8'h28, 10, 8'h30, 8'h01, 1'b0);
        t = 0;
        while (cap_n - s < 3 && t < 400) begin @(negedge clk); t++; end
        tick();
        soft_reset = 1'b1;
        fifo_flush = 1'b1;
        tick();
        soft_reset = 1'b0;
        fifo_flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({pkt_abort, out_valid, read_enb} !== 3'b100) begin
            tests_failed++;
            $display("FAIL sr_abort got abort=%b v=%b re=%b want 1 0 0", pkt_abort, out_valid, read_enb);
        end
        @(negedge clk);
        tests_run++;
        if (pkt_abort !== 1'b0) begin
            tests_failed++;
            $display("FAIL sr_abort_pulse got %b want 0", pkt_abort);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_n != d0 || abort_n - a0 != 1) begin
            tests_failed++;
            $display("FAIL sr_no_done got done=%0d aborts=%0d want 0 1", done_n - d0, abort_n - a0);
        end
        s = cap_n; d0 = done_n;
        load_pkt(8'h04, 1, 8'h5A, 8'h00, 1'b0);
        t = 0;
        while (done_n == d0 && t < 400) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        tests_run++;
        if (cap_n - s != 2 || cap[s] !== exp_beat[0] || cap[s + 1] !== exp_beat[1]) begin
            tests_failed++;
            $display("FAIL sr_next_pkt got n=%0d %h %h want 2 %h %h",
                     cap_n - s, cap[s], cap[s + 1], exp_beat[0], exp_beat[1]);
        end
        tests_run++;
        if (done_n == d0 || {last_perr, last_aerr} !== 2'b00) begin
            tests_failed++;
            $display("FAIL sr_next_status got perr=%b aerr=%b want 0 0", last_perr, last_aerr);
        end
    endtask

    task automatic test_rst_mid;
        int s, d0, t;
        s = cap_n;
        load_pkt(8'h28, 10, 8'h40, 8'h01, 1'b0);
        t = 0;
        while (!(cap_n - s >= 3 && read_enb) && t < 400) begin @(negedge clk); t++; end
        tick();
        rst = 1'b1;
        fifo_flush = 1'b1;
        tick();
        rst = 1'b0;
        fifo_flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({read_enb, out_valid, out_sop, out_eop, out_data, pkt_done, pkt_abort,
             parity_err, addr_err, pkt_count, err_count} !== 46'h0) begin
            tests_failed++;
            $display("FAIL rst_outputs got re=%b v=%b d=%h abort=%b cnt=%0d/%0d want all 0",
                     read_enb, out_valid, out_data, pkt_abort, pkt_count, err_count);
        end
        s = cap_n;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || cap_n != s) begin
            tests_failed++;
            $display("FAIL rst_stray_byte got v=%b beats=%0d want 0 0", out_valid, cap_n - s);
        end
        s = cap_n; d0 = done_n;
        load_pkt(8'h0C, 3, 8'h77, 8'h01, 1'b0);
        t = 0;
        while (done_n == d0 && t < 400) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        tests_run++;
        if (cap_n - s != exp_n || cap[s] !== exp_beat[0] || cap[s + 3] !== exp_beat[3]) begin
            tests_failed++;
            $display("FAIL rst_next_pkt got n=%0d %h %h want %0d %h %h",
                     cap_n - s, cap[s], cap[s + 3], exp_n, exp_beat[0], exp_beat[3]);
        end
        tests_run++;
        if (pkt_count !== (c_STATS ? 16'd1 : 16'd0)) begin
            tests_failed++;
            $display("FAIL rst_pkt_count got %0d", pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_addr_err();
        test_backpressure();
        test_soft_reset();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
